// File: rtl/mux_arb_pkg.sv
// Shared types for the two-way round-robin burst arbiter.
// State encoding, requester index and grant constants.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef logic req_idx_t;

    localparam logic [1:0] GNT_NONE = 2'b00;

    function automatic logic [1:0] onehot(input req_idx_t i);
        return i ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_beat_cnt.sv
// Loadable down-counter; load wins over dec, saturates at zero.
// Used for burst beats and, optionally, the stall watchdog.
module arb_beat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_last
);

    // Count register: reload on load, otherwise step down toward zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && value != '0) begin
            value <= value - W'(1);
        end
    end

    assign is_last = (value == W'(1));

endmodule

// File: rtl/mux2_arbiter.sv
// Two-way round-robin arbiter holding a grant for a counted burst.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
import mux_arb_pkg::*;

module mux2_arbiter #(
    parameter int LENW    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req,
    input  logic [LENW-1:0] len0,
    input  logic [LENW-1:0] len1,
    input  logic            rdy,
    output logic [1:0]      gnt,
    output logic            sel,
    output logic            busy,
    output logic            last,
    output logic            err
);

    localparam int CW = LENW + 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    arb_state_t    state;
    req_idx_t      prio;
    req_idx_t      cur;
    req_idx_t      other;
    req_idx_t      nidx;
    logic          do_grant;
    logic          beat_done;
    logic          fin;
    logic          abort;
    logic          cnt_last;
    logic [CW-1:0] beats0;
    logic [CW-1:0] beats1;
    logic [CW-1:0] load_val;
    logic [CW-1:0] rem;

    // A zero length means the full 2^LENW beats.
    assign beats0 = {(len0 == '0), len0};
    assign beats1 = {(len1 == '0), len1};

    assign busy      = |gnt;
    assign cur       = sel;
    assign other     = ~sel;
    assign beat_done = busy & rdy;
    assign fin       = beat_done & (rem == CW'(1));
    assign last      = busy & cnt_last;
    assign load_val  = nidx ? beats1 : beats0;

    // Pick who gets the resource next: from idle, or at the end of a burst.
    always_comb begin
        do_grant = 1'b0;
        nidx     = prio;
        if (state == IDLE) begin
            if (req != 2'b00) begin
                do_grant = 1'b1;
                nidx     = (req == 2'b11) ? prio : req[1];
            end
        end else if (fin) begin
            if (req[other]) begin
                do_grant = 1'b1;
                nidx     = other;
            end else if (req[cur]) begin
                do_grant = 1'b1;
                nidx     = cur;
            end
        end
    end

    arb_beat_cnt #(.W(CW)) u_beat (
        .clk      (clk),
        .reset    (reset),
        .load     (do_grant),
        .load_val (load_val),
        .dec      (beat_done),
        .value    (rem),
        .is_last  (cnt_last)
    );

`ifdef ARB_TIMEOUT_EN
    logic          stall_last;
    logic [SW-1:0] stall_val_unused;

    arb_beat_cnt #(.W(SW)) u_stall (
        .clk      (clk),
        .reset    (reset),
        .load     (do_grant | rdy),
        .load_val (SW'(TIMEOUT)),
        .dec      (busy & ~rdy),
        .value    (stall_val_unused),
        .is_last  (stall_last)
    );

    assign abort = busy & ~rdy & stall_last;

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (abort) begin
            err <= 1'b1;
        end
    end
`else
    logic [SW-1:0] unused_stall;

    assign unused_stall = '0;
    assign abort        = 1'b0;
    assign err          = 1'b0;
`endif

    // Grant, select, round-robin pointer and state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= GNT_NONE;
            sel   <= 1'b0;
            prio  <= 1'b0;
        end else begin
            if (fin || abort) begin
                prio <= other;
            end
            if (do_grant) begin
                state <= nidx ? GNT1 : GNT0;
                gnt   <= onehot(nidx);
                sel   <= nidx;
            end else if (fin || abort) begin
                state <= IDLE;
                gnt   <= GNT_NONE;
            end
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter with a queue-based scoreboard.
// A behavioural model predicts outputs for every driven cycle.
module tb_mux2_arbiter;

    localparam int LENW    = 3;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [1:0] gnt;
        logic       sel;
        logic       busy;
        logic       last;
        logic       err;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [1:0]      req;
    logic [LENW-1:0] len0;
    logic [LENW-1:0] len1;
    logic            rdy;
    logic [1:0]      gnt;
    logic            sel;
    logic            busy;
    logic            last;
    logic            err;

    int n_tests;
    int n_fail;
    exp_t sb[$];

    int m_g;
    int m_rem;
    int m_prio;
    int m_sel;
    int m_err;
    int m_stall;

    mux2_arbiter #(.LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .rdy   (rdy),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .last  (last),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int beats(input int l);
        return (l == 0) ? (1 << LENW) : l;
    endfunction

    task automatic m_grant(input int i);
        m_g     = i;
        m_sel   = i;
        m_rem   = beats(i == 1 ? int'(len1) : int'(len0));
        m_stall = 0;
    endtask

    task automatic m_reset();
        m_g = -1; m_rem = 0; m_prio = 0;
        m_sel = 0; m_err = 0; m_stall = 0;
        sb.delete();
    endtask

    task automatic m_step(input logic [1:0] r, input logic rd);
        int o;
        if (m_g < 0) begin
            if (r != 2'b00)
                m_grant((r == 2'b11) ? m_prio : (r == 2'b10 ? 1 : 0));
        end else if (rd) begin
            m_stall = 0;
            if (m_rem == 1) begin
                o = 1 - m_g;
                m_prio = o;
                if (r[o]) m_grant(o);
                else if (r[m_g]) m_grant(m_g);
                else begin m_g = -1; m_rem = 0; end
            end else begin
                m_rem--;
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            m_stall++;
            if (m_stall == TIMEOUT) begin
                m_prio  = 1 - m_g;
                m_g     = -1;
                m_rem   = 0;
                m_err   = 1;
                m_stall = 0;
            end
`endif
        end
    endtask

    function automatic exp_t m_out();
        exp_t e;
        e.gnt  = (m_g < 0) ? 2'b00 : (m_g == 1 ? 2'b10 : 2'b01);
        e.sel  = m_sel[0];
        e.busy = (m_g >= 0);
        e.last = (m_g >= 0) && (m_rem == 1);
        e.err  = m_err[0];
        return e;
    endfunction

    task automatic step(input logic [1:0] r, input logic rd, output logic b);
        exp_t e;
        req = r;
        rdy = rd;
        m_step(r, rd);
        sb.push_back(m_out());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt", int'(gnt), int'(e.gnt));
        chk("sel", int'(sel), int'(e.sel));
        chk("busy", int'(busy), int'(e.busy));
        chk("last", int'(last), int'(e.last));
        chk("err", int'(err), int'(e.err));
        b = busy;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_err", int'(err), 0);
        req = 2'b00;
        rdy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic b;
        int   nb;
        logic s [5];
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;
        rdy   = 1'b0;
        m_reset();
        #3;
        chk("init_gnt", int'(gnt), 0);
        chk("init_busy", int'(busy), 0);
        chk("init_sel", int'(sel), 0);
        chk("init_err", int'(err), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single requester, 3 beats.
        len0 = 3'd3;
        nb = 0;
        step(2'b01, 1'b1, b);
        chk("single_gnt_lat", int'(gnt), 1);
        nb += int'(b);
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'b1, b);
            nb += int'(b);
        end
        chk("single_busy_cnt", nb, 3);

        // Tie with fresh pointer: 0,0,1,1,0.
        do_reset();
        len0 = 3'd2;
        len1 = 3'd2;
        for (int i = 0; i < 5; i++) begin
            step(2'b11, 1'b1, b);
            s[i] = sel;
        end
        chk("tie_sel0", int'(s[0]), 0);
        chk("tie_sel1", int'(s[1]), 0);
        chk("tie_sel2", int'(s[2]), 1);
        chk("tie_sel3", int'(s[3]), 1);
        chk("tie_sel4", int'(s[4]), 0);
        step(2'b00, 1'b1, b);
        step(2'b00, 1'b1, b);
        chk("tie_idle", int'(busy), 0);

        // Backpressure on requester 1.
        len1 = 3'd2;
        step(2'b10, 1'b0, b);
        step(2'b00, 1'b0, b);
        step(2'b00, 1'b1, b);
        chk("bp_last", int'(last), 1);
        step(2'b00, 1'b0, b);
        step(2'b00, 1'b0, b);
        chk("bp_hold_gnt", int'(gnt), 2);
        step(2'b00, 1'b1, b);
        chk("bp_done", int'(busy), 0);

        // len0 = 0 means 8 beats.
        len0 = 3'd0;
        nb = 0;
        step(2'b01, 1'b1, b);
        nb += int'(b);
        for (int i = 0; i < 10; i++) begin
            step(2'b00, 1'b1, b);
            nb += int'(b);
        end
        chk("len0_busy_cnt", nb, 8);

        // Reset mid-burst, then a fresh 4-beat grant.
        len0 = 3'd4;
        step(2'b01, 1'b1, b);
        step(2'b00, 1'b1, b);
        step(2'b00, 1'b1, b);
        do_reset();
        nb = 0;
        step(2'b01, 1'b1, b);
        nb += int'(b);
        for (int i = 0; i < 6; i++) begin
            step(2'b00, 1'b1, b);
            nb += int'(b);
        end
        chk("rst_fresh_cnt", nb, 4);

`ifdef ARB_TIMEOUT_EN
        // Stall the resource until the watchdog aborts the burst.
        do_reset();
        len0 = 3'd2;
        step(2'b01, 1'b1, b);
        for (int i = 0; i < TIMEOUT; i++) begin
            step(2'b00, 1'b0, b);
        end
        chk("to_gnt", int'(gnt), 0);
        chk("to_err", int'(err), 1);
        len1 = 3'd1;
        step(2'b11, 1'b1, b);
        chk("to_rr_gnt", int'(gnt), 2);
        step(2'b00, 1'b1, b);
        chk("to_err_sticky", int'(err), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (memory or register-file write port) between two requesters.
- Drives the select line of the 2:1 datapath mux in front of that resource.
- Holds a grant for a multi-beat burst, counting beats against the resource's ready signal, then re-arbitrates.
- Sits between the requesting pipeline units and the mux/resource pair.

Parameters:
- LENW, 3: width of the burst-length inputs; maximum burst is 2^LENW beats.
- TIMEOUT, 16: stall-cycle limit used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  2  request per requester; bit i = requester i. Must stay high until granted.
- len0  input  LENW  burst beats for requester 0, sampled at grant. 0 means 2^LENW beats.
- len1  input  LENW  burst beats for requester 1, sampled at grant. Same encoding as len0.
- rdy  input  1  resource accepts the current beat this cycle.
- gnt  output  2  one-hot grant, registered.
- sel  output  1  mux select: 0 = requester 0, 1 = requester 1. Registered.
- busy  output  1  a grant is active.
- last  output  1  current beat is the final beat of the burst. Combinational from the count.
- err  output  1  sticky timeout flag. Tied 0 when the optional feature is out.

Behaviour:
- Reset (reset low, asynchronous): gnt=00, sel=0, busy=0, err=0, state IDLE, beat count 0, round-robin pointer prio=0. prio is the requester favoured on a tie.
- State machine: IDLE, GNT0, GNT1.
- IDLE:
  - If req != 00, grant at the next edge:
    - if req=01, go to GNT0; if req=10, go to GNT1;
    - if req=11, go to GNT{prio}.
  - Latency is one cycle from req high to gnt high.
  - On entry to GNTi: load remaining = len_i (0 maps to 2^LENW), set gnt[i], set sel=i, set busy.
- GNTi:
  - A beat completes on any cycle with rdy=1; remaining decrements.
  - last = (remaining == 1).
  - If rdy=0, hold all state and outputs.
  - On a completing last beat:
    - prio becomes the other requester.
    - If the other requester is requesting, switch directly to GNT(other) with no idle bubble.
    - Else if requester i is still requesting, re-grant i (back-to-back burst).
    - Else return to IDLE with gnt=00 and busy=0.
- Requests are ignored during a grant, so no pre-emption. Dropping req mid-burst does not end the burst; it completes on the beat count.
- sel holds its last value in IDLE, which avoids mux glitches.
- gnt is never 11. busy == |gnt at all times.
- Beat counter is LENW+1 bits so it can hold 2^LENW; no wrap.
- Reset asserted mid-burst aborts immediately to the reset values. No beat is counted on that edge.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A stall counter increments on each cycle with busy=1 and rdy=0, and clears on rdy=1.
  - When it reaches TIMEOUT, the burst is aborted: go to IDLE, gnt=00, prio flips, err set.
  - err stays set until reset.
- Not defined: no stall counter; err is constant 0; a burst waits on rdy indefinitely.

Decomposition:
- Package mux_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, GNT0, GNT1};
  - a one-bit requester index type;
  - localparam GNT_NONE = 2'b00.
- One sub-module, arb_beat_cnt:
  - loadable down-counter with load, dec, value and is_last;
  - also reused as the stall counter when ARB_TIMEOUT_EN is defined.

Test Plan:
- Reset mid-burst: req=01, len0=4, two beats done, then pulse reset low → gnt=00, busy=0, sel=0 asynchronously; after release, req=01 gives a fresh grant with 4 beats.
- Single requester: req=01, len0=3, rdy=1 constant → gnt=01 one cycle after req; busy for exactly 3 cycles; last high on the 3rd beat; then IDLE.
- Tie and round-robin: req=11, len0=len1=2, rdy=1 → GNT0 for 2 beats, then GNT1 with no bubble; sel goes 0,0,1,1; then GNT0 again.
- Backpressure: req=10, len1=2, rdy pattern 0,1,0,0,1 → last asserted from the first completed beat onward; burst ends on the 5th cycle; outputs stable while rdy=0.
- len=0 encoding with LENW=3: req=01, len0=0, rdy=1 → exactly 8 beats before release.
- ARB_TIMEOUT_EN with TIMEOUT=16: grant held with rdy=0 for 16 cycles → abort, gnt=00, err=1 sticky; next tie (req=11) is granted to the other requester.
